// File: rtl/wb_stage_q.sv
// Write-back stage with an in-order retire queue merging MEM and long-latency results.
// Define WB_TRACE_EN to store per-entry PCs and drive the debug_wb_* trace ports.
module wb_stage_q #(
  parameter int XLEN  = 32,
  parameter int PCW   = 32,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ms_to_ws_valid,
  input  logic [1+5+XLEN+PCW-1:0] ms_to_ws_bus,
  output logic                    ws_allowin,
  input  logic                    lu_valid,
  input  logic [5+XLEN+PCW-1:0]   lu_bus,
  output logic                    lu_ready,
  input  logic                    rf_wr_ready,
  output logic                    rf_we,
  output logic [4:0]              rf_waddr,
  output logic [XLEN-1:0]         rf_wdata,
  output logic [31:0]             ws_busy_mask,
  output logic [PCW-1:0]          debug_wb_pc,
  output logic [3:0]              debug_wb_rf_we,
  output logic [4:0]              debug_wb_rf_wnum,
  output logic [XLEN-1:0]         debug_wb_rf_wdata
);
  localparam int AW = $clog2(DEPTH);
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  logic            r_we   [DEPTH];
  logic [4:0]      r_dest [DEPTH];
  logic [XLEN-1:0] r_data [DEPTH];
  ptr_t            r_head;
  ptr_t            r_tail;
  cnt_t            r_count;

  logic            w_ms_we;
  logic [4:0]      w_ms_dest;
  logic [XLEN-1:0] w_ms_data;
  logic [PCW-1:0]  w_ms_pc;
  logic [4:0]      w_lu_dest;
  logic [XLEN-1:0] w_lu_data;
  logic [PCW-1:0]  w_lu_pc;

  assign w_ms_we   = ms_to_ws_bus[XLEN+PCW+5];
  assign w_ms_dest = ms_to_ws_bus[XLEN+PCW +: 5];
  assign w_ms_data = ms_to_ws_bus[PCW +: XLEN];
  assign w_ms_pc   = ms_to_ws_bus[PCW-1:0];
  assign w_lu_dest = lu_bus[XLEN+PCW +: 5];
  assign w_lu_data = lu_bus[PCW +: XLEN];
  assign w_lu_pc   = lu_bus[PCW-1:0];

  cnt_t w_free;
  logic w_push_m;
  logic w_push_l;
  logic w_empty;
  logic w_pop;
  ptr_t w_lu_slot;

  // free is from registered count only; a same-cycle pop is not credited
  assign w_free     = cnt_t'(DEPTH) - r_count;
  assign ws_allowin = (w_free != '0);
  assign lu_ready   = (w_free >= cnt_t'(2)) ||
                      ((w_free == cnt_t'(1)) && !ms_to_ws_valid);
  assign w_push_m   = ms_to_ws_valid && ws_allowin;
  assign w_push_l   = lu_valid && lu_ready;
  assign w_lu_slot  = r_tail + ptr_t'(w_push_m);

  assign w_empty  = (r_count == '0);
  assign w_pop    = !w_empty && (!r_we[r_head] || rf_wr_ready);
  assign rf_we    = !reset && !w_empty && r_we[r_head];
  assign rf_waddr = w_empty ? '0 : r_dest[r_head];
  assign rf_wdata = w_empty ? '0 : r_data[r_head];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + ptr_t'(w_pop);
      r_tail  <= r_tail + ptr_t'(w_push_m) + ptr_t'(w_push_l);
      r_count <= r_count + cnt_t'(w_push_m) + cnt_t'(w_push_l)
                 - cnt_t'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_m) begin
      r_we[r_tail]   <= w_ms_we && (w_ms_dest != 5'd0);
      r_dest[r_tail] <= w_ms_dest;
      r_data[r_tail] <= w_ms_data;
    end
    if (w_push_l) begin
      r_we[w_lu_slot]   <= (w_lu_dest != 5'd0);
      r_dest[w_lu_slot] <= w_lu_dest;
      r_data[w_lu_slot] <= w_lu_data;
    end
  end

  ptr_t w_off;
  always_comb begin
    ws_busy_mask = '0;
    w_off        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off = ptr_t'(i) - r_head;
      if (({1'b0, w_off} < r_count) && r_we[i])
        ws_busy_mask[r_dest[i]] = 1'b1;
    end
    ws_busy_mask[0] = 1'b0;
  end

`ifdef WB_TRACE_EN
  logic [PCW-1:0] r_pc [DEPTH];

  always_ff @(posedge clk) begin
    if (w_push_m) r_pc[r_tail]    <= w_ms_pc;
    if (w_push_l) r_pc[w_lu_slot] <= w_lu_pc;
  end

  assign debug_wb_pc       = w_empty ? '0 : r_pc[r_head];
  assign debug_wb_rf_we    = {4{rf_we && rf_wr_ready}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
`else
  logic w_unused;
  assign w_unused          = ^{w_ms_pc, w_lu_pc};
  assign debug_wb_pc       = '0;
  assign debug_wb_rf_we    = '0;
  assign debug_wb_rf_wnum  = '0;
  assign debug_wb_rf_wdata = '0;
`endif

endmodule

// File: tb/tb_wb_stage_q.sv
// Directed self-checking bench for wb_stage_q.
// Trace expectations follow WB_TRACE_EN.
module tb_wb_stage_q;
  localparam int XLEN  = 32;
  localparam int PCW   = 32;
  localparam int DEPTH = 4;
`ifdef WB_TRACE_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    ms_to_ws_valid;
  logic [1+5+XLEN+PCW-1:0] ms_to_ws_bus;
  logic                    ws_allowin;
  logic                    lu_valid;
  logic [5+XLEN+PCW-1:0]   lu_bus;
  logic                    lu_ready;
  logic                    rf_wr_ready;
  logic                    rf_we;
  logic [4:0]              rf_waddr;
  logic [XLEN-1:0]         rf_wdata;
  logic [31:0]             ws_busy_mask;
  logic [PCW-1:0]          debug_wb_pc;
  logic [3:0]              debug_wb_rf_we;
  logic [4:0]              debug_wb_rf_wnum;
  logic [XLEN-1:0]         debug_wb_rf_wdata;

  int n_chk  = 0;
  int n_fail = 0;

  wb_stage_q #(.XLEN(XLEN), .PCW(PCW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .ws_allowin(ws_allowin),
    .lu_valid(lu_valid), .lu_bus(lu_bus), .lu_ready(lu_ready),
    .rf_wr_ready(rf_wr_ready), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ws_busy_mask(ws_busy_mask),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ms(input logic v, input logic we, input logic [4:0] d,
                    input logic [31:0] data, input logic [31:0] pc);
    ms_to_ws_valid = v;
    ms_to_ws_bus   = {we, d, data, pc};
  endtask

  task automatic lu(input logic v, input logic [4:0] d,
                    input logic [31:0] data, input logic [31:0] pc);
    lu_valid = v;
    lu_bus   = {d, data, pc};
  endtask

  logic [36:0] q[$];
  int sent;
  int got;

  initial begin
    reset       = 1'b1;
    rf_wr_ready = 1'b1;
    ms(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    lu(1'b0, 5'd0, 32'd0, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_allowin", 64'(ws_allowin), 64'd1);
    chk("rst_lu_ready", 64'(lu_ready), 64'd1);
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_busy", 64'(ws_busy_mask), 64'd0);
    chk("rst_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_wdata", 64'(rf_wdata), 64'd0);
    chk("rst_dbg_we", 64'(debug_wb_rf_we), 64'd0);
    chk("rst_dbg_pc", 64'(debug_wb_pc), 64'd0);

    // single MEM entry
    tick();
    ms(1'b1, 1'b1, 5'd5, 32'h1234, 32'h1c000000);
    #1;
    chk("t1_allowin", 64'(ws_allowin), 64'd1);
    tick();
    ms(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    #1;
    chk("t1_rf_we", 64'(rf_we), 64'd1);
    chk("t1_waddr", 64'(rf_waddr), 64'd5);
    chk("t1_wdata", 64'(rf_wdata), 64'h1234);
    chk("t1_busy", 64'(ws_busy_mask), 64'h20);
    chk("t1_dbg_we", 64'(debug_wb_rf_we), TR ? 64'hf : 64'h0);
    chk("t1_dbg_pc", 64'(debug_wb_pc), TR ? 64'h1c000000 : 64'h0);
    chk("t1_dbg_wnum", 64'(debug_wb_rf_wnum), TR ? 64'd5 : 64'd0);
    tick();
    chk("t1_rf_we_after", 64'(rf_we), 64'd0);
    chk("t1_busy_after", 64'(ws_busy_mask), 64'd0);

    // MEM and LU together on an empty queue
    ms(1'b1, 1'b1, 5'd3, 32'haaaa, 32'h1c000010);
    lu(1'b1, 5'd7, 32'hbbbb, 32'h1c000014);
    #1;
    chk("t2_allowin", 64'(ws_allowin), 64'd1);
    chk("t2_lu_ready", 64'(lu_ready), 64'd1);
    tick();
    ms(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    lu(1'b0, 5'd0, 32'd0, 32'd0);
    #1;
    chk("t2_waddr0", 64'(rf_waddr), 64'd3);
    chk("t2_wdata0", 64'(rf_wdata), 64'haaaa);
    chk("t2_busy0", 64'(ws_busy_mask), 64'h88);
    tick();
    chk("t2_waddr1", 64'(rf_waddr), 64'd7);
    chk("t2_wdata1", 64'(rf_wdata), 64'hbbbb);
    chk("t2_busy1", 64'(ws_busy_mask), 64'h80);
    chk("t2_dbg_pc1", 64'(debug_wb_pc), TR ? 64'h1c000014 : 64'h0);
    tick();
    chk("t2_busy2", 64'(ws_busy_mask), 64'd0);
    chk("t2_rf_we2", 64'(rf_we), 64'd0);

    // stall then stream 3*DEPTH entries across pointer wrap
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      rf_wr_ready = (cyc > DEPTH);
      ms(sent < 3*DEPTH, 1'b1, 5'((sent % 30) + 1),
         32'h1000 + 32'(sent), 32'h1c000100 + 32'(sent));
      #1;
      if (cyc == DEPTH) begin
        chk("t3_full_allowin", 64'(ws_allowin), 64'd0);
        chk("t3_full_lu_ready", 64'(lu_ready), 64'd0);
        chk("t3_full_rf_we", 64'(rf_we), 64'd1);
      end
      if (rf_we && rf_wr_ready) begin
        chk("t3_ret_waddr", 64'(rf_waddr), 64'(q[0][36:32]));
        chk("t3_ret_wdata", 64'(rf_wdata), 64'(q[0][31:0]));
        void'(q.pop_front());
        got++;
      end
      if (ms_to_ws_valid && ws_allowin) begin
        q.push_back({5'((sent % 30) + 1), 32'h1000 + 32'(sent)});
        sent++;
      end
      tick();
      if (got == 3*DEPTH) break;
    end
    ms(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    #1;
    chk("t3_sent", 64'(sent), 64'(3*DEPTH));
    chk("t3_got", 64'(got), 64'(3*DEPTH));
    chk("t3_q_empty", 64'(q.size()), 64'd0);
    chk("t3_rf_we_end", 64'(rf_we), 64'd0);

    // free == 1 with both sources valid
    tick();
    rf_wr_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      ms(1'b1, 1'b1, 5'(k), 32'h11 * 32'(k), 32'h1c000200);
      tick();
    end
    ms(1'b1, 1'b1, 5'd4, 32'h44, 32'h1c000204);
    lu(1'b1, 5'd8, 32'h88, 32'h1c000208);
    rf_wr_ready = 1'b1;
    #1;
    chk("t4_allowin", 64'(ws_allowin), 64'd1);
    chk("t4_lu_ready", 64'(lu_ready), 64'd0);
    chk("t4_head", 64'(rf_waddr), 64'd1);
    tick();
    ms(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    #1;
    chk("t4_lu_ready2", 64'(lu_ready), 64'd1);
    chk("t4_head2", 64'(rf_waddr), 64'd2);
    tick();
    lu(1'b0, 5'd0, 32'd0, 32'd0);
    #1;
    chk("t4_busy", 64'(ws_busy_mask), 64'h118);
    chk("t4_head3", 64'(rf_waddr), 64'd3);
    tick();
    chk("t4_head4", 64'(rf_waddr), 64'd4);
    chk("t4_wdata4", 64'(rf_wdata), 64'h44);
    tick();
    chk("t4_head8", 64'(rf_waddr), 64'd8);
    chk("t4_wdata8", 64'(rf_wdata), 64'h88);
    tick();
    chk("t4_empty", 64'(rf_we), 64'd0);

    // dest 0 entry pops despite a busy write port
    rf_wr_ready = 1'b0;
    ms(1'b1, 1'b1, 5'd0, 32'hdead, 32'h1c000040);
    tick();
    ms(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    #1;
    chk("t5_rf_we", 64'(rf_we), 64'd0);
    chk("t5_busy", 64'(ws_busy_mask), 64'd0);
    chk("t5_dbg_pc", 64'(debug_wb_pc), TR ? 64'h1c000040 : 64'h0);
    chk("t5_dbg_we", 64'(debug_wb_rf_we), 64'd0);
    tick();
    rf_wr_ready = 1'b1;
    ms(1'b1, 1'b1, 5'd9, 32'h99, 32'h1c000044);
    tick();
    ms(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    #1;
    chk("t5_next_waddr", 64'(rf_waddr), 64'd9);
    chk("t5_next_wdata", 64'(rf_wdata), 64'h99);
    tick();

    // reset with three entries queued
    rf_wr_ready = 1'b0;
    for (int k = 10; k <= 12; k++) begin
      ms(1'b1, 1'b1, 5'(k), 32'(k), 32'h1c000300);
      tick();
    end
    ms(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    #1;
    chk("t6_busy_pre", 64'(ws_busy_mask), 64'h1c00);
    reset       = 1'b1;
    rf_wr_ready = 1'b1;
    #1;
    chk("t6_rf_we_in_rst", 64'(rf_we), 64'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("t6_rf_we", 64'(rf_we), 64'd0);
    chk("t6_busy", 64'(ws_busy_mask), 64'd0);
    chk("t6_allowin", 64'(ws_allowin), 64'd1);
    chk("t6_lu_ready", 64'(lu_ready), 64'd1);
    chk("t6_waddr", 64'(rf_waddr), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_stage_q.md
# wb_stage_q

Parametrised write-back stage with an in-order retire queue that merges two result sources into the single register-file write port of the five-stage LoongArch pipeline. The two sources are the main MEM→WB pipeline and the long-latency unit (divider/multiplier). Results are buffered in a DEPTH-entry FIFO and retired one per cycle, gated by write-port availability. The stage exports a pending-destination mask for decode-stage hazard detection and a per-retire debug trace.

## Interface

Parameters:
- XLEN, 32, data width of result and register-file write data.
- PCW, 32, PC width carried for trace.
- DEPTH, 4, retire-queue entries; power of two, ≥2.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- ms_to_ws_valid  in  1  MEM stage presents an entry.
- ms_to_ws_bus  in  1+5+XLEN+PCW  {gr_we, dest[4:0], result, pc}, MSB first.
- ws_allowin  out  1  WB accepts an MEM entry this cycle.
- lu_valid  in  1  long-latency unit presents a result.
- lu_bus  in  5+XLEN+PCW  {dest, result, pc}; gr_we implicitly 1.
- lu_ready  out  1  WB accepts the LU result this cycle.
- rf_wr_ready  in  1  register-file write port is free this cycle (shared with CSR path).
- rf_we  out  1  write request for the queue head.
- rf_waddr  out  5  head destination.
- rf_wdata  out  XLEN  head result.
- ws_busy_mask  out  32  bit r set while any queued entry writes GR r.
- debug_wb_pc  out  PCW  PC of the entry retiring this cycle.
- debug_wb_rf_we  out  4  {4{write committed}}.
- debug_wb_rf_wnum  out  5  destination of the retiring entry.
- debug_wb_rf_wdata  out  XLEN  data of the retiring entry.

## Operation

- Circular FIFO with head/tail pointers of log2(DEPTH) bits, wrapping naturally, and a count of log2(DEPTH)+1 bits. free = DEPTH − count, taken from registered state only; the same-cycle pop is not credited.
- Enqueue normalisation: if dest == 0, gr_we is cleared.
- Each MEM entry is queued, including gr_we = 0 entries, so the trace keeps every retired instruction.
- ws_allowin = (free ≥ 1).
- lu_ready = (free ≥ 2) || (free == 1 && !ms_to_ws_valid). MEM has priority.
- Push occurs on valid && ready for each source. When both sources push in the same cycle, the MEM entry takes slot tail and the LU entry takes tail+1, so MEM retires first.
- Head outputs: rf_we = !empty && head.gr_we; rf_waddr and rf_wdata reflect the head continuously.
- pop = !empty && (!head.gr_we || rf_wr_ready). A write commits when rf_we && rf_wr_ready.
- count_next = count + pushes − pop. A simultaneous push and pop on a full queue is impossible, because allowin is computed from pre-pop free.
- ws_busy_mask is the OR over valid entries with gr_we of one-hot(dest). It is combinational from queue state and includes the head until the cycle after it pops. Bit 0 is always 0.
- Reset clears count and pointers. Entry contents are not reset.

## Timing

- MEM→RF latency is 1 cycle minimum: an entry pushed in cycle N can be written in cycle N+1.
- Throughput is one retire per cycle; up to two pushes per cycle.
- rf_wr_ready low stalls only a head with gr_we = 1. A no-write head pops regardless.
- Reset values: ws_allowin = 1 and lu_ready = 1 (queue empty); rf_we = 0; ws_busy_mask = 0; all debug outputs 0.
- rf_waddr and rf_wdata are don't-care while rf_we = 0, but must not be X after reset when the queue is empty; drive 0 when empty.
- Reset asserted mid-operation discards all queued entries. No write is issued in the reset cycle.

## Configuration

- WB_TRACE_EN defined:
  - PC is stored per entry.
  - On each pop, debug_wb_pc, debug_wb_rf_wnum and debug_wb_rf_wdata show the head; debug_wb_rf_we = {4{rf_we && rf_wr_ready}}.
  - With no pop, debug_wb_rf_we = 0 and the other debug outputs hold the head values.
- WB_TRACE_EN undefined:
  - PC field is not stored; the pc input bits are ignored.
  - All debug_* ports are tied to 0.
  - All other behaviour is identical.

## Test plan

- Single MEM entry {we=1, dest=5, result=0x1234, pc=0x1c000000}, rf_wr_ready=1 -> next cycle rf_we=1, waddr=5, wdata=0x1234; ws_busy_mask bit5 set for exactly one cycle; debug_wb_rf_we=4'hf.
- MEM and LU valid together on an empty queue (MEM dest=3, LU dest=7) -> both accepted; retire order 3 then 7 on consecutive cycles; busy_mask 0x88 then 0x80 then 0.
- Hold rf_wr_ready=0 with MEM streaming we=1 entries -> after DEPTH pushes ws_allowin=0 and lu_ready=0. Release rf_wr_ready -> queue drains one per cycle; no entry is lost or duplicated across pointer wrap (push 3×DEPTH entries total).
- free == 1 with MEM valid and LU valid -> MEM accepted, lu_ready=0. Next cycle MEM idle -> LU accepted.
- MEM entry with dest=0, gr_we=1, and rf_wr_ready=0 -> pops anyway; rf_we=0; busy_mask=0; trace PC shown with debug_wb_rf_we=0.
- Assert reset for one cycle with 3 entries queued -> next cycle count=0, rf_we=0, busy_mask=0, ws_allowin=1.
